// File: rtl/arch_defs_pkg.sv
// Shared architectural definitions: processor flag image type, bit positions, reset value.
package arch_defs_pkg;

  typedef logic [3:0] flags_t;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_V = 3;

  localparam flags_t FLAGS_RESET = '0;

endpackage

// File: rtl/flags_shadow_stack.sv
// LIFO register file for saved flag sets. Pushes are rejected when full and pops when empty.
module flags_shadow_stack #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [WIDTH-1:0]             data_i,
  output logic [WIDTH-1:0]             top_o,
  output logic [$clog2(DEPTH+1)-1:0]   depth_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int unsigned DW = $clog2(DEPTH+1);

  logic [DW-1:0]    depth_q, depth_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             full, empty, do_push, do_pop;

  assign full    = (depth_q == DW'(DEPTH));
  assign empty   = (depth_q == '0);
  assign do_push = push_i & ~full;
  assign do_pop  = pop_i & ~empty & ~push_i;

  always_comb begin
    depth_d = depth_q;
    mem_d   = mem_q;
    if (do_push) begin
      depth_d = depth_q + DW'(1);
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (depth_q == DW'(i)) mem_d[i] = data_i;
      end
    end else if (do_pop) begin
      depth_d = depth_q - DW'(1);
    end
  end

  // Top of stack is the entry just below the occupancy count.
  always_comb begin
    top_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (depth_q == DW'(i + 1)) top_o = mem_q[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) depth_q <= '0;
    else       depth_q <= depth_d;
  end

  // Entry contents need no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign depth_o = depth_q;
  assign full_o  = full;
  assign empty_o = empty;

endmodule

// File: rtl/status_flags_unit.sv
// Processor status register: V/N/C/Z capture from ALU, bus restore, SEC/CLC,
// and a shadow stack for interrupt entry/exit with a sticky stack error flag.
module status_flags_unit
  import arch_defs_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned SHADOW_DEPTH = 4,
  parameter int unsigned NUM_FLAGS    = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [DATA_WIDTH-1:0]             alu_result_i,
  input  logic                              alu_carry_i,
  input  logic                              alu_overflow_i,
  input  logic [NUM_FLAGS-1:0]              load_mask_i,
  input  logic                              bus_load_i,
  input  logic [NUM_FLAGS-1:0]              bus_data_i,
  input  logic                              set_carry_i,
  input  logic                              clr_carry_i,
  input  logic                              push_i,
  input  logic                              pop_i,
  input  logic                              err_clr_i,
  output logic [NUM_FLAGS-1:0]              flags_o,
  output logic                              flag_zero_o,
  output logic                              flag_carry_o,
  output logic                              flag_negative_o,
  output logic                              flag_overflow_o,
  output logic [$clog2(SHADOW_DEPTH+1)-1:0] depth_o,
  output logic                              full_o,
  output logic                              empty_o,
  output logic                              stack_err_o
);

  localparam int unsigned DEPTH_W = $clog2(SHADOW_DEPTH+1);

  flags_t flags_q, flags_d;
  logic   err_q, err_d;
  flags_t alu_flags, stk_top;
  logic   stk_push, stk_pop, stk_full, stk_empty, valid_pop, new_err;
  logic [DEPTH_W-1:0] stk_depth;

  // Simultaneous push+pop is an error that leaves the stack untouched.
  assign stk_push  = push_i & ~pop_i;
  assign stk_pop   = pop_i & ~push_i;
  assign valid_pop = stk_pop & ~stk_empty;
  assign new_err   = (push_i & pop_i) | (stk_push & stk_full) | (stk_pop & stk_empty);

  flags_shadow_stack #(
    .WIDTH (4),
    .DEPTH (SHADOW_DEPTH)
  ) u_shadow_stack (
    .clk     (clk),
    .reset   (reset),
    .push_i  (stk_push),
    .pop_i   (stk_pop),
    .data_i  (flags_q),
    .top_o   (stk_top),
    .depth_o (stk_depth),
    .full_o  (stk_full),
    .empty_o (stk_empty)
  );

  always_comb begin
    alu_flags         = '0;
    alu_flags[FLAG_Z] = (alu_result_i == '0);
    alu_flags[FLAG_C] = alu_carry_i;
    alu_flags[FLAG_N] = alu_result_i[DATA_WIDTH-1];
    alu_flags[FLAG_V] = alu_overflow_i;
  end

  always_comb begin
    flags_d = flags_q;
    if (valid_pop) begin
      flags_d = stk_top;
    end else if (bus_load_i) begin
      flags_d = bus_data_i;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (load_mask_i[i]) flags_d[i] = alu_flags[i];
      end
      // An ALU carry capture takes precedence over SEC/CLC.
      if (!load_mask_i[FLAG_C]) begin
        if (set_carry_i && !clr_carry_i)      flags_d[FLAG_C] = 1'b1;
        else if (clr_carry_i && !set_carry_i) flags_d[FLAG_C] = 1'b0;
      end
    end
  end

  always_comb begin
    err_d = err_q;
    if (err_clr_i) err_d = 1'b0;
    if (new_err)   err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= FLAGS_RESET;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  assign flags_o         = flags_q;
  assign flag_zero_o     = flags_q[FLAG_Z];
  assign flag_carry_o    = flags_q[FLAG_C];
  assign flag_negative_o = flags_q[FLAG_N];
  assign flag_overflow_o = flags_q[FLAG_V];
  assign depth_o         = stk_depth;
  assign full_o          = stk_full;
  assign empty_o         = stk_empty;
  assign stack_err_o     = err_q;

endmodule

// File: tb/tb_status_flags_unit.sv
// Table-driven bench for status_flags_unit with a queue of expected post-edge states.
module tb_status_flags_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] alu_result_i;
  logic       alu_carry_i, alu_overflow_i;
  logic [3:0] load_mask_i;
  logic       bus_load_i;
  logic [3:0] bus_data_i;
  logic       set_carry_i, clr_carry_i, push_i, pop_i, err_clr_i;
  logic [3:0] flags_o;
  logic       flag_zero_o, flag_carry_o, flag_negative_o, flag_overflow_o;
  logic [2:0] depth_o;
  logic       full_o, empty_o, stack_err_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] res;
    logic       c, v;
    logic [3:0] mask;
    logic       bl;
    logic [3:0] bd;
    logic       sec, clc, push, pop, eclr;
    logic [3:0] ef;
    logic [2:0] ed;
    logic       ee;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  status_flags_unit #(
    .DATA_WIDTH   (8),
    .SHADOW_DEPTH (4),
    .NUM_FLAGS    (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .alu_result_i    (alu_result_i),
    .alu_carry_i     (alu_carry_i),
    .alu_overflow_i  (alu_overflow_i),
    .load_mask_i     (load_mask_i),
    .bus_load_i      (bus_load_i),
    .bus_data_i      (bus_data_i),
    .set_carry_i     (set_carry_i),
    .clr_carry_i     (clr_carry_i),
    .push_i          (push_i),
    .pop_i           (pop_i),
    .err_clr_i       (err_clr_i),
    .flags_o         (flags_o),
    .flag_zero_o     (flag_zero_o),
    .flag_carry_o    (flag_carry_o),
    .flag_negative_o (flag_negative_o),
    .flag_overflow_o (flag_overflow_o),
    .depth_o         (depth_o),
    .full_o          (full_o),
    .empty_o         (empty_o),
    .stack_err_o     (stack_err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(logic [7:0] res, logic c, logic v, logic [3:0] mask,
                              logic bl, logic [3:0] bd, logic sec, logic clc,
                              logic push, logic pop, logic eclr,
                              logic [3:0] ef, logic [2:0] ed, logic ee);
    vec_t r;
    r.res = res; r.c = c; r.v = v; r.mask = mask; r.bl = bl; r.bd = bd;
    r.sec = sec; r.clc = clc; r.push = push; r.pop = pop; r.eclr = eclr;
    r.ef = ef; r.ed = ed; r.ee = ee;
    return r;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [3:0] ef, input logic [2:0] ed,
                             input logic ee);
    cmp({tag, ".flags"}, 32'(flags_o), 32'(ef));
    cmp({tag, ".z"}, 32'(flag_zero_o), 32'(ef[0]));
    cmp({tag, ".c"}, 32'(flag_carry_o), 32'(ef[1]));
    cmp({tag, ".n"}, 32'(flag_negative_o), 32'(ef[2]));
    cmp({tag, ".v"}, 32'(flag_overflow_o), 32'(ef[3]));
    cmp({tag, ".depth"}, 32'(depth_o), 32'(ed));
    cmp({tag, ".full"}, 32'(full_o), 32'(ed == 3'd4));
    cmp({tag, ".empty"}, 32'(empty_o), 32'(ed == 3'd0));
    cmp({tag, ".err"}, 32'(stack_err_o), 32'(ee));
  endtask

  task automatic drive_idle();
    alu_result_i = 8'h00; alu_carry_i = 1'b0; alu_overflow_i = 1'b0;
    load_mask_i = 4'h0; bus_load_i = 1'b0; bus_data_i = 4'h0;
    set_carry_i = 1'b0; clr_carry_i = 1'b0; push_i = 1'b0; pop_i = 1'b0;
    err_clr_i = 1'b0;
  endtask

  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    @(negedge clk);
    alu_result_i = v.res; alu_carry_i = v.c; alu_overflow_i = v.v;
    load_mask_i = v.mask; bus_load_i = v.bl; bus_data_i = v.bd;
    set_carry_i = v.sec; clr_carry_i = v.clc; push_i = v.push; pop_i = v.pop;
    err_clr_i = v.eclr;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s.scoreboard: got empty queue expected one entry", tag);
    end else begin
      e = exp_q.pop_front();
      check_state(tag, e.ef, e.ed, e.ee);
    end
  endtask

  initial begin
    drive_idle();
    reset = 1'b1;
    #12 reset = 1'b0;
    #1 check_state("reset", 4'b0000, 3'd0, 1'b0);

    //            res    c  v  mask    bl bd      sec clc psh pop clr ef       ed    ee
    tbl.push_back(mk(8'h00, 1, 0, 4'hF,   0, 4'h0,  0, 0, 0, 0, 0, 4'b0011, 3'd0, 0));
    tbl.push_back(mk(8'h80, 0, 1, 4'b1100, 0, 4'h0, 0, 0, 0, 0, 0, 4'b1111, 3'd0, 0));
    tbl.push_back(mk(8'h00, 0, 0, 4'h0,   0, 4'h0,  1, 1, 0, 0, 0, 4'b1111, 3'd0, 0));
    tbl.push_back(mk(8'h00, 0, 0, 4'h0,   0, 4'h0,  0, 1, 0, 0, 0, 4'b1101, 3'd0, 0));
    tbl.push_back(mk(8'h00, 0, 0, 4'h0,   0, 4'h0,  1, 0, 0, 0, 0, 4'b1111, 3'd0, 0));
    tbl.push_back(mk(8'h00, 0, 0, 4'b0010, 0, 4'h0, 1, 0, 0, 0, 0, 4'b1101, 3'd0, 0));
    tbl.push_back(mk(8'h00, 0, 0, 4'h0,   1, 4'h1,  0, 0, 0, 0, 0, 4'b0001, 3'd0, 0));
    tbl.push_back(mk(8'h00, 0, 0, 4'h0,   1, 4'h2,  0, 0, 1, 0, 0, 4'b0010, 3'd1, 0));
    tbl.push_back(mk(8'h00, 0, 0, 4'h0,   1, 4'h4,  0, 0, 1, 0, 0, 4'b0100, 3'd2, 0));
    tbl.push_back(mk(8'h00, 0, 0, 4'h0,   1, 4'h8,  0, 0, 1, 0, 0, 4'b1000, 3'd3, 0));
    tbl.push_back(mk(8'h00, 0, 0, 4'h0,   0, 4'h0,  0, 0, 1, 0, 0, 4'b1000, 3'd4, 0));
    tbl.push_back(mk(8'h00, 0, 0, 4'h0,   0, 4'h0,  0, 0, 1, 0, 0, 4'b1000, 3'd4, 1));
    tbl.push_back(mk(8'h00, 0, 0, 4'h0,   0, 4'h0,  0, 0, 0, 0, 1, 4'b1000, 3'd4, 0));
    tbl.push_back(mk(8'h00, 0, 0, 4'h0,   0, 4'h0,  0, 0, 0, 1, 0, 4'b1000, 3'd3, 0));
    tbl.push_back(mk(8'h00, 1, 0, 4'hF,   1, 4'h0,  0, 0, 0, 1, 0, 4'b0100, 3'd2, 0));
    tbl.push_back(mk(8'h00, 0, 0, 4'h0,   0, 4'h0,  0, 0, 0, 1, 0, 4'b0010, 3'd1, 0));
    tbl.push_back(mk(8'h00, 0, 0, 4'h0,   0, 4'h0,  0, 0, 0, 1, 0, 4'b0001, 3'd0, 0));
    tbl.push_back(mk(8'h01, 0, 0, 4'hF,   0, 4'h0,  0, 0, 0, 1, 0, 4'b0000, 3'd0, 1));
    tbl.push_back(mk(8'h00, 0, 0, 4'h0,   0, 4'h0,  0, 0, 0, 0, 1, 4'b0000, 3'd0, 0));
    tbl.push_back(mk(8'h00, 0, 0, 4'h0,   0, 4'h0,  0, 0, 0, 1, 1, 4'b0000, 3'd0, 1));
    tbl.push_back(mk(8'h00, 0, 0, 4'h0,   0, 4'h0,  0, 0, 0, 0, 1, 4'b0000, 3'd0, 0));
    tbl.push_back(mk(8'h00, 0, 0, 4'h0,   1, 4'hA,  0, 0, 0, 0, 0, 4'b1010, 3'd0, 0));
    tbl.push_back(mk(8'hFF, 1, 0, 4'hF,   0, 4'h0,  0, 0, 1, 0, 0, 4'b0110, 3'd1, 0));
    tbl.push_back(mk(8'h00, 0, 0, 4'h0,   1, 4'h5,  0, 0, 1, 1, 0, 4'b0101, 3'd1, 1));
    tbl.push_back(mk(8'h00, 0, 0, 4'h0,   0, 4'h0,  0, 0, 0, 1, 0, 4'b1010, 3'd0, 1));
    tbl.push_back(mk(8'h00, 0, 0, 4'h0,   0, 4'h0,  0, 0, 0, 0, 1, 4'b1010, 3'd0, 0));
    tbl.push_back(mk(8'h00, 0, 0, 4'h0,   1, 4'h0,  1, 0, 0, 0, 0, 4'b0000, 3'd0, 0));
    tbl.push_back(mk(8'h7F, 0, 1, 4'hF,   0, 4'h0,  0, 0, 0, 0, 0, 4'b1000, 3'd0, 0));

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Asynchronous reset while the stack is partly filled.
    apply(mk(8'h00, 0, 0, 4'h0, 1, 4'hF, 0, 0, 0, 0, 0, 4'b1111, 3'd0, 0), "seq_fill0");
    apply(mk(8'h00, 0, 0, 4'h0, 0, 4'h0, 0, 0, 1, 0, 0, 4'b1111, 3'd1, 0), "seq_fill1");
    apply(mk(8'h00, 0, 0, 4'h0, 0, 4'h0, 0, 0, 1, 0, 0, 4'b1111, 3'd2, 0), "seq_fill2");
    apply(mk(8'h00, 0, 0, 4'h0, 0, 4'h0, 0, 0, 1, 0, 0, 4'b1111, 3'd3, 0), "seq_fill3");
    #2 reset = 1'b1;
    #1 check_state("async_reset", 4'b0000, 3'd0, 1'b0);
    drive_idle();
    #3 reset = 1'b0;
    apply(mk(8'h00, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0, 4'b0000, 3'd0, 0), "post_reset_idle");
    apply(mk(8'h00, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 1, 0, 4'b0000, 3'd0, 1), "post_reset_pop");

    @(negedge clk);
    drive_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
